// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic; imported by the fetch top and its skid buffer.
// No flow control.
package instruction_fetch_stage_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  // FETCH: nothing outstanding; WAIT: one live request; DROP: one request whose data is dead
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register used while decode is frozen.
// Latency: loaded data is visible the cycle after load.
// Backpressure: none internally; the owner must not load while skid_vld is set.
module fetch_skid_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   unload,
  input  logic                   clear,
  input  logic [ADDR_WIDTH-1:0]  load_pc,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  output logic                   skid_vld,
  output logic [ADDR_WIDTH-1:0]  skid_pc,
  output logic [INSTR_WIDTH-1:0] skid_instr
);

  // Clear wins over load so a branch always leaves the buffer empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP_WORD;
    end else if (clear) begin
      skid_vld <= 1'b0;
    end else if (load) begin
      skid_vld   <= 1'b1;
      skid_pc    <= load_pc;
      skid_instr <= load_instr;
    end else if (unload) begin
      skid_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, one outstanding imem request, IF/ID register, perf counters under IF_PERF_COUNTERS_EN.
// Latency: request at t, 1-cycle memory responds at t+1, valid at t+2; 1 instr/cycle sustained.
// Backpressure: freeze holds IF/ID; one in-flight response parks in the skid and fetch stops until it drains.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchAddr,
  output logic                   imemReq,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemValid,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [ADDR_WIDTH-1:0]  pcOut,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]            fetchCount,
  output logic [31:0]            stallCount
`endif
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  fetch_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   skid_vld;
  logic [ADDR_WIDTH-1:0]  skid_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic frozen, room, req, rsp_acc;
  logic load_from_skid, load_from_rsp, skid_load;

  // A held valid entry plus an arriving word would need a second skid slot, so no new request then.
  assign frozen  = freeze && valid;
  assign room    = !skid_vld && !(frozen && imemValid);
  assign req     = room && !branchTaken &&
                   ((state == FETCH) || ((state == WAIT) && imemValid));
  assign imemReq = req && !rst;
  assign imemAddr = pc;

  // Only a WAIT response survives; DROP data and data coinciding with a branch are discarded.
  assign rsp_acc        = (state == WAIT) && imemValid && !branchTaken;
  assign load_from_skid = !branchTaken && !frozen && skid_vld;
  assign load_from_rsp  = !branchTaken && !frozen && !skid_vld && rsp_acc;
  assign skid_load      = !branchTaken && frozen && rsp_acc;

  fetch_skid_buffer #(.ADDR_WIDTH(ADDR_WIDTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (load_from_skid),
    .clear      (branchTaken),
    .load_pc    (req_addr + STEP),
    .load_instr (imemData),
    .skid_vld   (skid_vld),
    .skid_pc    (skid_pc),
    .skid_instr (skid_instr)
  );

  // Fetch state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next state: track whether the single outstanding request is live, dead or absent.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (req) state_nxt = WAIT;
      WAIT: begin
        if (branchTaken)    state_nxt = imemValid ? FETCH : DROP;
        else if (req)       state_nxt = WAIT;
        else if (imemValid) state_nxt = FETCH;
      end
      DROP:    if (imemValid) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // PC redirect on branch, otherwise advance and remember the address of each issued request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (branchTaken) begin
      pc <= branchAddr;
    end else if (req) begin
      pc       <= pc + STEP;
      req_addr <= pc;
    end
  end

  // IF/ID register: skid drains first, then a fresh response, otherwise a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      pcOut       <= '0;
      instruction <= NOP_WORD;
    end else if (branchTaken) begin
      valid <= 1'b0;
    end else if (!frozen) begin
      if (load_from_skid) begin
        valid       <= 1'b1;
        pcOut       <= skid_pc;
        instruction <= skid_instr;
      end else if (load_from_rsp) begin
        valid       <= 1'b1;
        pcOut       <= req_addr + STEP;
        instruction <= imemData;
      end else begin
        valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  // Saturating counters of delivered instructions and frozen cycles; branches leave them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if ((load_from_skid || load_from_rsp) && (fetchCount != 32'hFFFF_FFFF))
        fetchCount <= fetchCount + 32'd1;
      if (frozen && (stallCount != 32'hFFFF_FFFF))
        stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed cycle table for the fetch stage plus hand sequences for async reset and perf counters.
// Inputs change on the falling edge; outputs are sampled 1ns later, before the next rising edge.
// Memory responses are scripted per cycle in the table rather than modelled.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] pcOut;
  logic [31:0] instruction;
  logic        valid;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branchTaken (branchTaken),
    .branchAddr  (branchAddr),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemValid   (imemValid),
    .imemData    (imemData),
    .pcOut       (pcOut),
    .instruction (instruction),
    .valid       (valid)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetchCount  (fetchCount),
    .stallCount  (stallCount)
`endif
  );

  typedef struct {
    logic        fr;
    logic        br;
    logic [31:0] baddr;
    logic        iv;
    logic [31:0] idat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fr, input logic br, input logic [31:0] baddr,
                     input logic iv, input logic [31:0] idat,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.fr = fr; v.br = br; v.baddr = baddr; v.iv = iv; v.idat = idat;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_ins = e_ins;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic br, input logic [31:0] baddr,
                       input logic iv, input logic [31:0] idat);
    freeze = fr; branchTaken = br; branchAddr = baddr; imemValid = iv; imemData = idat;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    //  fr br baddr         iv idat          | req addr          vld pcOut         instr
    add(0, 0, 0,            0, 0,            1, 32'h0,           0, 0,            0);
    add(0, 0, 0,            1, 32'h1000_0000, 1, 32'h4,          0, 0,            0);
    add(0, 0, 0,            1, 32'h1000_0004, 1, 32'h8,          1, 32'h4,        32'h1000_0000);
    add(0, 0, 0,            1, 32'h1000_0008, 1, 32'hC,          1, 32'h8,        32'h1000_0004);
    // freeze for three cycles while a response lands -> skid fills, fetch stops
    add(1, 0, 0,            1, 32'h1000_000C, 0, 32'h10,         1, 32'hC,        32'h1000_0008);
    add(1, 0, 0,            0, 0,            0, 32'h10,          1, 32'hC,        32'h1000_0008);
    add(1, 0, 0,            0, 0,            0, 32'h10,          1, 32'hC,        32'h1000_0008);
    add(0, 0, 0,            0, 0,            0, 32'h10,          1, 32'hC,        32'h1000_0008);
    add(0, 0, 0,            0, 0,            1, 32'h10,          1, 32'h10,       32'h1000_000C);
    // branch while waiting; late response two cycles later is discarded
    add(0, 1, 32'h100,      0, 0,            0, 32'h14,          0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h100,         0, 0,            0);
    add(0, 0, 0,            1, 32'hDEAD_BEEF, 0, 32'h100,        0, 0,            0);
    add(0, 0, 0,            0, 0,            1, 32'h100,         0, 0,            0);
    add(0, 0, 0,            1, 32'h1000_0100, 1, 32'h104,        0, 0,            0);
    // branch + response + freeze together
    add(1, 1, 32'h200,      1, 32'hBAD0_0001, 0, 32'h108,        1, 32'h104,      32'h1000_0100);
    add(1, 0, 0,            0, 0,            1, 32'h200,         0, 0,            0);
    // 5-cycle memory latency
    add(0, 0, 0,            0, 0,            0, 32'h204,         0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h204,         0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h204,         0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h204,         0, 0,            0);
    add(0, 0, 0,            1, 32'h1000_0200, 1, 32'h204,        0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h208,         1, 32'h204,      32'h1000_0200);
    add(0, 0, 0,            0, 0,            0, 32'h208,         0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h208,         0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h208,         0, 0,            0);
    add(0, 0, 0,            1, 32'h1000_0204, 1, 32'h208,        0, 0,            0);
    // branch to the top of the address space -> pc wraps
    add(0, 1, 32'hFFFF_FFFC, 0, 0,           0, 32'h20C,         1, 32'h208,      32'h1000_0204);
    add(0, 0, 0,            1, 32'hBAD0_0002, 0, 32'hFFFF_FFFC,  0, 0,            0);
    add(0, 0, 0,            0, 0,            1, 32'hFFFF_FFFC,   0, 0,            0);
    add(0, 0, 0,            1, 32'h1FFF_FFFC, 1, 32'h0,          0, 0,            0);
    add(0, 0, 0,            0, 0,            0, 32'h4,           1, 32'h0,        32'h1FFF_FFFC);

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_req",   {31'b0, imemReq}, 32'h0);
    chk("reset_valid", {31'b0, valid},   32'h0);
    chk("reset_pcout", pcOut,            32'h0);
    chk("reset_instr", instruction,      32'h0);
    chk("reset_addr",  imemAddr,         32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fr, tbl[i].br, tbl[i].baddr, tbl[i].iv, tbl[i].idat);
      #1;
      chk($sformatf("c%0d_req", i),   {31'b0, imemReq}, {31'b0, tbl[i].e_req});
      chk($sformatf("c%0d_addr", i),  imemAddr,         tbl[i].e_addr);
      chk($sformatf("c%0d_valid", i), {31'b0, valid},   {31'b0, tbl[i].e_vld});
      if (tbl[i].e_vld) begin
        chk($sformatf("c%0d_pcout", i), pcOut,       tbl[i].e_pc);
        chk($sformatf("c%0d_instr", i), instruction, tbl[i].e_ins);
      end
      @(negedge clk);
    end

    // async reset with a request outstanding: outputs clear without a clock edge
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req",   {31'b0, imemReq}, 32'h0);
    chk("midrst_valid", {31'b0, valid},   32'h0);
    chk("midrst_pcout", pcOut,            32'h0);
    chk("midrst_instr", instruction,      32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_req",  {31'b0, imemReq}, 32'h1);
    chk("postrst_addr", imemAddr,         32'h0);

`ifdef IF_PERF_COUNTERS_EN
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 1, 32'h2000_0000 + k);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    #1;
    chk("perf_fetch", fetchCount, 32'd10);
    chk("perf_stall", stallCount, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("perf_fetch_rst", fetchCount, 32'd0);
    chk("perf_stall_rst", stallCount, 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
